// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and FSM state encoding for the instruction fetch unit.
// The states use a 2-bit encoding that other datapath blocks also rely on.
package instr_fetch_unit_pkg;

   localparam int IFU_WORD_SIZE   = 16;
   localparam int IFU_TIMEOUT_CYC = 255;
   localparam int IFU_PERF_WIDTH  = 32;

   typedef enum logic [1:0] {
      IF_IDLE    = 2'd0,
      IF_REQ     = 2'd1,
      IF_CAPTURE = 2'd2
   } if_state_t;

endpackage

// File: rtl/instr_fetch_unit_timeout_ctr.sv
// Cycle counter for the REQ state. It is cleared outside REQ and flags expiry on the LIMIT-th
// counted cycle. A LIMIT of 0 disables expiry.
module fetch_timeout_ctr #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
   localparam logic [CW-1:0] LAST = (LIMIT == 0) ? '0 : CW'(LIMIT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   assign expire = enable && (LIMIT != 0) && (count == LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: latches the PC, runs a readM/inputReady handshake, and loads the IR.
// Optional macro FETCH_PERF_CNT_EN adds the fetch_count and stall_count performance counters.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int WORD_SIZE   = IFU_WORD_SIZE,
   parameter int TIMEOUT_CYC = IFU_TIMEOUT_CYC
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [WORD_SIZE-1:0] pc_cur,
   input  logic                 fetch_start,
   input  logic                 flush,
   output logic                 readM,
   output logic [WORD_SIZE-1:0] address,
   input  logic [WORD_SIZE-1:0] data,
   input  logic                 inputReady,
   output logic [WORD_SIZE-1:0] ir,
   output logic                 ir_valid,
   output logic [WORD_SIZE-1:0] pc_plus1,
   output logic                 busy,
   output logic                 fetch_err
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [IFU_PERF_WIDTH-1:0] fetch_count,
   output logic [IFU_PERF_WIDTH-1:0] stall_count
`endif
);

   if_state_t state;
   logic      tmo_clear;
   logic      tmo_enable;
   logic      tmo_expire;

   assign tmo_clear  = (state != IF_REQ);
   assign tmo_enable = (state == IF_REQ) && !inputReady && !flush;

   fetch_timeout_ctr #(
      .LIMIT (TIMEOUT_CYC)
   ) u_timeout (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (tmo_clear),
      .enable  (tmo_enable),
      .expire  (tmo_expire)
   );

   // Flush has priority over a same-cycle completion, and completion beats a timeout.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IF_IDLE;
         readM     <= 1'b0;
         ir_valid  <= 1'b0;
         fetch_err <= 1'b0;
         busy      <= 1'b0;
         address   <= '0;
         ir        <= '0;
         pc_plus1  <= '0;
      end else begin
         ir_valid  <= 1'b0;
         fetch_err <= 1'b0;
         case (state)
            IF_IDLE: begin
               if (fetch_start && !flush) begin
                  address  <= pc_cur;
                  pc_plus1 <= pc_cur + 1'b1;
                  readM    <= 1'b1;
                  busy     <= 1'b1;
                  state    <= IF_REQ;
               end
            end
            IF_REQ: begin
               if (flush) begin
                  readM <= 1'b0;
                  busy  <= 1'b0;
                  state <= IF_IDLE;
               end else if (inputReady) begin
                  ir       <= data;
                  readM    <= 1'b0;
                  ir_valid <= 1'b1;
                  state    <= IF_CAPTURE;
               end else if (tmo_expire) begin
                  readM     <= 1'b0;
                  busy      <= 1'b0;
                  fetch_err <= 1'b1;
                  state     <= IF_IDLE;
               end
            end
            IF_CAPTURE: begin
               busy  <= 1'b0;
               state <= IF_IDLE;
            end
            default: begin
               readM <= 1'b0;
               busy  <= 1'b0;
               state <= IF_IDLE;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   // Both counters saturate rather than wrap so long runs never report a misleadingly small count.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fetch_count <= '0;
         stall_count <= '0;
      end else begin
         if (ir_valid && (fetch_count != '1)) begin
            fetch_count <= fetch_count + 1'b1;
         end
         if ((state == IF_REQ) && !inputReady && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed fetches push expected IR results, and a
// negedge monitor compares them whenever ir_valid or fetch_err fires.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] pc_cur;
   logic        fetch_start;
   logic        flush;
   logic        readM;
   logic [15:0] address;
   logic [15:0] data;
   logic        inputReady;
   logic [15:0] ir;
   logic        ir_valid;
   logic [15:0] pc_plus1;
   logic        busy;
   logic        fetch_err;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count;
   logic [31:0] stall_count;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] ir;
      logic [15:0] addr;
      logic [15:0] pcp1;
   } exp_t;

   exp_t expQ[$];
   logic [15:0] errQ[$];

   always #5 clk = ~clk;

   instr_fetch_unit #(
      .TIMEOUT_CYC (4)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .pc_cur      (pc_cur),
      .fetch_start (fetch_start),
      .flush       (flush),
      .readM       (readM),
      .address     (address),
      .data        (data),
      .inputReady  (inputReady),
      .ir          (ir),
      .ir_valid    (ir_valid),
      .pc_plus1    (pc_plus1),
      .busy        (busy),
      .fetch_err   (fetch_err)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_count (fetch_count),
      .stall_count (stall_count)
`endif
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, then return just after the edge that sampled them.
   task automatic applyStimulus(input logic fs, input logic fl, input logic rdy, input logic [15:0] d);
      fetch_start = fs;
      flush       = fl;
      inputReady  = rdy;
      data        = d;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (ir_valid) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_ir_valid", 32'(ir_valid), 32'd0);
         end else begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("sb_ir", 32'(ir), 32'(e.ir));
            checkOutput("sb_address", 32'(address), 32'(e.addr));
            checkOutput("sb_pc_plus1", 32'(pc_plus1), 32'(e.pcp1));
         end
      end
      if (fetch_err) begin
         if (errQ.size() == 0) begin
            checkOutput("unexpected_fetch_err", 32'(fetch_err), 32'd0);
         end else begin
            logic [15:0] a;
            a = errQ.pop_front();
            checkOutput("sb_err_address", 32'(address), 32'(a));
         end
      end
   end

   initial begin
      reset_n = 1'b0;
      pc_cur  = 16'h0000;
      applyStimulus(0, 0, 0, 16'h0000);
      applyStimulus(0, 0, 0, 16'h0000);
      checkOutput("rst_readM", 32'(readM), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_ir", 32'(ir), 32'd0);
      checkOutput("rst_address", 32'(address), 32'd0);
      checkOutput("rst_pc_plus1", 32'(pc_plus1), 32'd0);
      checkOutput("rst_ir_valid", 32'(ir_valid), 32'd0);
      checkOutput("rst_fetch_err", 32'(fetch_err), 32'd0);
      reset_n = 1'b1;

      // Normal fetch with two wait cycles
      pc_cur = 16'h0010;
      expQ.push_back('{ir: 16'hA5C3, addr: 16'h0010, pcp1: 16'h0011});
      applyStimulus(1, 0, 0, 16'h0000);
      checkOutput("t2_readM", 32'(readM), 32'd1);
      checkOutput("t2_busy", 32'(busy), 32'd1);
      checkOutput("t2_address", 32'(address), 32'h0010);
      checkOutput("t2_pc_plus1", 32'(pc_plus1), 32'h0011);
      applyStimulus(0, 0, 0, 16'h0000);
      applyStimulus(0, 0, 0, 16'h0000);
      checkOutput("t2_wait_ir_valid", 32'(ir_valid), 32'd0);
      applyStimulus(0, 0, 1, 16'hA5C3);
      checkOutput("t2_cap_ir_valid", 32'(ir_valid), 32'd1);
      checkOutput("t2_cap_readM", 32'(readM), 32'd0);
      checkOutput("t2_cap_busy", 32'(busy), 32'd1);
      checkOutput("t2_cap_ir", 32'(ir), 32'hA5C3);
      applyStimulus(0, 0, 0, 16'h0000);
      checkOutput("t2_pulse_end", 32'(ir_valid), 32'd0);
      checkOutput("t2_idle_busy", 32'(busy), 32'd0);

      // Fetch at the PC reset value wraps pc_plus1
      pc_cur = 16'hFFFF;
      expQ.push_back('{ir: 16'h0F0F, addr: 16'hFFFF, pcp1: 16'h0000});
      applyStimulus(1, 0, 0, 16'h0000);
      checkOutput("t3_address", 32'(address), 32'hFFFF);
      checkOutput("t3_pc_plus1", 32'(pc_plus1), 32'h0000);
      applyStimulus(0, 0, 1, 16'h0F0F);
      applyStimulus(0, 0, 0, 16'h0000);

      // Flush with a simultaneous completion discards the data
      pc_cur = 16'h0020;
      applyStimulus(1, 0, 0, 16'h0000);
      applyStimulus(0, 0, 0, 16'h0000);
      applyStimulus(0, 1, 1, 16'h1234);
      checkOutput("t4_readM", 32'(readM), 32'd0);
      checkOutput("t4_busy", 32'(busy), 32'd0);
      checkOutput("t4_ir", 32'(ir), 32'h0F0F);
      checkOutput("t4_ir_valid", 32'(ir_valid), 32'd0);
      applyStimulus(0, 0, 0, 16'h0000);
      pc_cur = 16'h0028;
      applyStimulus(1, 1, 0, 16'h0000);
      checkOutput("t4_flush_start_busy", 32'(busy), 32'd0);
      checkOutput("t4_flush_start_addr", 32'(address), 32'h0020);

      // Timeout after four REQ cycles
      pc_cur = 16'h0030;
      errQ.push_back(16'h0030);
      applyStimulus(1, 0, 0, 16'h0000);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 16'h0000);
         checkOutput("t5_wait_readM", 32'(readM), 32'd1);
         checkOutput("t5_wait_err", 32'(fetch_err), 32'd0);
      end
      applyStimulus(0, 0, 0, 16'h0000);
      checkOutput("t5_fetch_err", 32'(fetch_err), 32'd1);
      checkOutput("t5_readM", 32'(readM), 32'd0);
      checkOutput("t5_busy", 32'(busy), 32'd0);
      applyStimulus(0, 0, 0, 16'h0000);
      checkOutput("t5_err_pulse_end", 32'(fetch_err), 32'd0);

      // Reset asserted in the middle of a REQ
      pc_cur = 16'h0040;
      applyStimulus(1, 0, 0, 16'h0000);
      applyStimulus(0, 0, 0, 16'h0000);
      reset_n = 1'b0;
      applyStimulus(0, 0, 0, 16'h0000);
      applyStimulus(0, 0, 0, 16'h0000);
      checkOutput("t1_readM", 32'(readM), 32'd0);
      checkOutput("t1_busy", 32'(busy), 32'd0);
      checkOutput("t1_ir", 32'(ir), 32'd0);
      checkOutput("t1_address", 32'(address), 32'd0);
      reset_n = 1'b1;
      applyStimulus(0, 0, 1, 16'h7777);
      checkOutput("t1_idle_busy", 32'(busy), 32'd0);
      checkOutput("t1_idle_ir", 32'(ir), 32'd0);
`ifdef FETCH_PERF_CNT_EN
      checkOutput("t1_fetch_count", fetch_count, 32'd0);
      checkOutput("t1_stall_count", stall_count, 32'd0);
`endif

      // fetch_start during REQ and CAPTURE is dropped
      pc_cur = 16'h0050;
      expQ.push_back('{ir: 16'hBEEF, addr: 16'h0050, pcp1: 16'h0051});
      applyStimulus(1, 0, 0, 16'h0000);
      pc_cur = 16'h0060;
      applyStimulus(1, 0, 0, 16'h0000);
      applyStimulus(1, 0, 0, 16'h0000);
      applyStimulus(0, 0, 1, 16'hBEEF);
      applyStimulus(1, 0, 0, 16'h0000);
      applyStimulus(0, 0, 0, 16'h0000);
      checkOutput("t6_busy", 32'(busy), 32'd0);
      checkOutput("t6_address", 32'(address), 32'h0050);
`ifdef FETCH_PERF_CNT_EN
      checkOutput("t6_fetch_count", fetch_count, 32'd1);
      checkOutput("t6_stall_count", stall_count, 32'd2);
`endif
      applyStimulus(0, 0, 1, 16'hDEAD);
      checkOutput("t6_ready_in_idle_ir", 32'(ir), 32'hBEEF);
      checkOutput("t6_ready_in_idle_busy", 32'(busy), 32'd0);

      applyStimulus(0, 0, 0, 16'h0000);
      applyStimulus(0, 0, 0, 16'h0000);
      checkOutput("sb_expected_left", 32'(expQ.size()), 32'd0);
      checkOutput("sb_err_left", 32'(errQ.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
